// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a FIFO client and fifo_param.
// The client (master) drives requests and write data; the FIFO (slave)
// returns head data, occupancy and flags.
interface fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) ();
   logic              flush;
   logic              push;
   logic [DATA_W-1:0] w_data;
   logic              pop;
   logic              clr_err;
   logic [DATA_W-1:0] r_data;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, push, w_data, pop, clr_err,
      input  r_data, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  flush, push, w_data, pop, clr_err,
      output r_data, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous show-ahead FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags and a synchronous flush. A push while full is accepted
// when a pop happens in the same cycle (pass-through at full).
module fifo_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input logic         clk,
   input logic         rst,   // asynchronous, active-low
   fifo_param_if.slave bus
);
   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

   // Storage: written synchronously, read combinationally from r_ptr.
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic full, empty;
   logic wr_en, rd_en;
   logic ovf_set, udf_set;

   // Status flags decoded from the registered occupancy.
   always_comb begin
      full  = (count_q == DEPTH_C);
      empty = (count_q == '0);
   end

   // Accepted operations, error set conditions and next-state values.
   // Flush overrides push/pop for the cycle but leaves the error flags alone.
   always_comb begin
      wr_en   = bus.push & (~full | bus.pop) & ~bus.flush;
      rd_en   = bus.pop & ~empty & ~bus.flush;
      ovf_set = bus.push & full & ~bus.pop & ~bus.flush;
      udf_set = bus.pop & empty & ~bus.flush;

      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;

      if (bus.flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         count_d = '0;
      end else begin
         if (wr_en) w_ptr_d = w_ptr_q + ADDR_W'(1);
         if (rd_en) r_ptr_d = r_ptr_q + ADDR_W'(1);
         if (wr_en && !rd_en)      count_d = count_q + (ADDR_W + 1)'(1);
         else if (rd_en && !wr_en) count_d = count_q - (ADDR_W + 1)'(1);
      end

      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow_d  = ovf_set | (overflow_q  & ~bus.clr_err);
      underflow_d = udf_set | (underflow_q & ~bus.clr_err);
   end

   // Pointer, count and error-flag registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[w_ptr_q] <= bus.w_data;
   end

   assign bus.r_data       = empty ? '0 : mem[r_ptr_q];
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: a queue scoreboard tracks expected
// contents and error flags; each scenario task checks the DUT inline.
module tb_fifo_param;
   localparam int DEPTH = 16;

   logic clk;
   logic rst;

   fifo_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   fifo_param #(
      .DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb[$];
   bit m_ovf = 1'b0;
   bit m_udf = 1'b0;

   // One clock of stimulus; updates the scoreboard and returns the word
   // that was on r_data before the edge together with the word expected
   // to leave the FIFO on that edge.
   task automatic step(input bit ps, input logic [7:0] wd, input bit pp,
                       input bit fl, input bit ce, output bit popped,
                       output logic [7:0] got, output logic [7:0] exp);
      bit was_full, was_empty, ovf_set, udf_set;
      bus.push = ps; bus.w_data = wd; bus.pop = pp;
      bus.flush = fl; bus.clr_err = ce;
      got = bus.r_data;
      popped = 1'b0;
      exp = 8'h00;
      was_full  = (sb.size() == DEPTH);
      was_empty = (sb.size() == 0);
      ovf_set = !fl && ps && was_full && !pp;
      udf_set = !fl && pp && was_empty;
      if (ovf_set) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (udf_set) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
      if (fl) sb.delete();
      else begin
         if (pp && !was_empty) begin exp = sb.pop_front(); popped = 1'b1; end
         if (ps && (!was_full || pp)) sb.push_back(wd);
      end
      @(posedge clk); #1;
      bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
      $display("t=%0t push=%0b wd=%02h pop=%0b flush=%0b clr=%0b -> count=%0d r_data=%02h ovf=%0b udf=%0b",
               $time, ps, wd, pp, fl, ce, bus.count, bus.r_data, bus.overflow, bus.underflow);
   endtask

   // Stimulus only: push n words base, base+1, ...
   task automatic fill(input int n, input logic [7:0] base);
      bit p; logic [7:0] g, e;
      for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0, p, g, e);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
      bus.w_data = 8'h00;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      n_cmp++; if (bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got=%b exp=1", bus.almost_empty); end
      n_cmp++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
      n_cmp++; if (bus.r_data !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%02h exp=00", bus.r_data); end
      n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         n_err++; $display("FAIL reset_err got=%b%b exp=00", bus.overflow, bus.underflow); end
   endtask

   task automatic test_fill_drain();
      bit p; logic [7:0] g, e;
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (bus.count !== 5'(i)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); end
         n_cmp++; if (bus.almost_full !== (i >= 12)) begin n_err++; $display("FAIL fill_af count=%0d got=%b", i, bus.almost_full); end
         n_cmp++; if (bus.full !== (i == 16)) begin n_err++; $display("FAIL fill_full count=%0d got=%b", i, bus.full); end
         n_cmp++; if (bus.r_data !== 8'h01) begin n_err++; $display("FAIL fill_head got=%02h exp=01", bus.r_data); end
      end
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e || e !== 8'(i)) begin n_err++; $display("FAIL drain_data got=%02h exp=%02h", g, 8'(i)); end
         n_cmp++; if (bus.count !== 5'(16 - i)) begin n_err++; $display("FAIL drain_count got=%0d exp=%0d", bus.count, 16 - i); end
         n_cmp++; if (bus.almost_empty !== ((16 - i) <= 4)) begin n_err++; $display("FAIL drain_ae count=%0d got=%b", 16 - i, bus.almost_empty); end
         n_cmp++; if (bus.empty !== (i == 16)) begin n_err++; $display("FAIL drain_empty count=%0d got=%b", 16 - i, bus.empty); end
      end
   endtask

   task automatic test_errors();
      bit p; logic [7:0] g, e;
      fill(16, 8'h20);
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
      n_cmp++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e || g !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL ovf_drain got=%02h exp=%02h", g, 8'h20 + 8'(i)); end
      end
      n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL ovf_dropped empty=%b r_data=%02h", bus.empty, bus.r_data); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b1) begin
         n_err++; $display("FAIL udf_set got ovf=%b udf=%b exp 1 1", bus.overflow, bus.underflow); end
      n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p, g, e);
      n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         n_err++; $display("FAIL clr_err got ovf=%b udf=%b exp 0 0", bus.overflow, bus.underflow); end
      fill(16, 8'h30);
      step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, p, g, e);
      n_cmp++; if (bus.overflow !== m_ovf || bus.overflow !== 1'b1) begin
         n_err++; $display("FAIL set_beats_clr got=%b exp=1", bus.overflow); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p, g, e);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e) begin n_err++; $display("FAIL err_drain got=%02h exp=%02h", g, e); end
      end
   endtask

   task automatic test_simultaneous();
      bit p; logic [7:0] g, e, last;
      fill(16, 8'h40);
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (!p || g !== 8'h40) begin n_err++; $display("FAIL full_pass_head got=%02h exp=40", g); end
      n_cmp++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
         n_err++; $display("FAIL full_pass_count got=%0d full=%b exp=16 1", bus.count, bus.full); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_pass_ovf got=%b exp=0", bus.overflow); end
      last = 8'h00;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e) begin n_err++; $display("FAIL full_pass_drain got=%02h exp=%02h", g, e); end
         last = g;
      end
      n_cmp++; if (last !== 8'h55) begin n_err++; $display("FAIL full_pass_last got=%02h exp=55", last); end
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (bus.count !== 5'd1 || bus.r_data !== 8'h33) begin
         n_err++; $display("FAIL empty_pushpop got count=%0d r_data=%02h exp 1 33", bus.count, bus.r_data); end
      n_cmp++; if (bus.underflow !== 1'b1 || p) begin n_err++; $display("FAIL empty_pushpop_udf got=%b exp=1", bus.underflow); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p, g, e);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (!p || g !== 8'h33) begin n_err++; $display("FAIL empty_pushpop_read got=%02h exp=33", g); end
   endtask

   task automatic test_wrap();
      bit p; logic [7:0] g, e;
      fill(3, 8'h60);
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 8'h63 + 8'(k), 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e || g !== 8'h60 + 8'(k)) begin
            n_err++; $display("FAIL wrap_data k=%0d got=%02h exp=%02h", k, g, 8'h60 + 8'(k)); end
         n_cmp++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL wrap_count got=%0d exp=3", bus.count); end
         n_cmp++; if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow} !== 6'b000100) begin
            n_err++; $display("FAIL wrap_flags got=%b exp=000100",
               {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow}); end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
         n_cmp++; if (!p || g !== e) begin n_err++; $display("FAIL wrap_drain got=%02h exp=%02h", g, e); end
      end
   endtask

   task automatic test_flush();
      bit p; logic [7:0] g, e;
      fill(7, 8'h70);
      n_cmp++; if (bus.count !== 5'd7) begin n_err++; $display("FAIL flush_pre got=%0d exp=7", bus.count); end
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, p, g, e);
      n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.r_data !== 8'h00) begin
         n_err++; $display("FAIL flush_clear got count=%0d empty=%b r_data=%02h exp 0 1 00", bus.count, bus.empty, bus.r_data); end
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (bus.r_data !== 8'h77 || bus.count !== 5'd1) begin
         n_err++; $display("FAIL flush_after got r_data=%02h count=%0d exp 77 1", bus.r_data, bus.count); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
   endtask

   task automatic test_async_reset();
      bit p; logic [7:0] g, e;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);   // underflow on empty
      fill(5, 8'h80);
      #2 rst = 1'b0;                                 // mid-cycle, no clk edge
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      #1;
      n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.r_data !== 8'h00) begin
         n_err++; $display("FAIL async_rst got count=%0d empty=%b r_data=%02h exp 0 1 00", bus.count, bus.empty, bus.r_data); end
      n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL async_rst_udf got=%b exp=0", bus.underflow); end
      @(posedge clk); #3 rst = 1'b1;
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (bus.r_data !== 8'h99 || bus.count !== 5'd1) begin
         n_err++; $display("FAIL post_rst_push got r_data=%02h count=%0d exp 99 1", bus.r_data, bus.count); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      n_cmp++; if (!p || g !== e || bus.empty !== 1'b1) begin
         n_err++; $display("FAIL post_rst_pop got=%02h exp=%02h", g, e); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_errors();
      test_simultaneous();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout: bench did not finish (compared=%0d)", n_cmp);
      $fatal(1);
   end
endmodule
